// File: rtl/sd_sector_word_streamer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sd_sector_word_streamer_if                                        |
// | Brief  : Sector capture, burst control and word-stream bundle.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface sd_sector_word_streamer_if #(
  parameter int SECTOR_BITS = 4096,
  parameter int WORD_W      = 32
);
  localparam int NWORDS = SECTOR_BITS / WORD_W;
  localparam int AW     = $clog2(NWORDS);

  logic                   sec_valid;
  logic [SECTOR_BITS-1:0] sec_data;
  logic                   sec_ready;
  // "release" is a reserved word, hence the suffix
  logic                   release_req;
  logic                   start;
  logic [AW-1:0]          start_addr;
  logic [AW:0]            count;
  logic                   busy;
  logic                   word_valid;
  logic                   word_ready;
  logic [WORD_W-1:0]      word_data;
  logic [AW-1:0]          word_addr;
  logic                   done;
  logic                   err;

  modport slave (
    input  sec_valid, sec_data, release_req, start, start_addr, count, word_ready,
    output sec_ready, busy, word_valid, word_data, word_addr, done, err
  );

  modport master (
    output sec_valid, sec_data, release_req, start, start_addr, count, word_ready,
    input  sec_ready, busy, word_valid, word_data, word_addr, done, err
  );
endinterface
`default_nettype wire

// File: rtl/sd_sector_word_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sd_sector_word_streamer                                           |
// | Brief  : Buffers one SD sector and streams it as words with wrap-around.   |
// |          Define SD_RDIV_BYTESWAP_EN to byte-reverse each output word.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sd_sector_word_streamer #(
  parameter int SECTOR_BITS = 4096,
  parameter int WORD_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  sd_sector_word_streamer_if.slave bus
);
  localparam int NWORDS = SECTOR_BITS / WORD_W;
  localparam int AW     = $clog2(NWORDS);
  localparam int CNT_W  = AW + 1;
  localparam int NBYTES = WORD_W / 8;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOADED = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [NWORDS-1:0][WORD_W-1:0]  buf_q, buf_d;
  logic [AW-1:0]                  ptr_q, ptr_d;
  logic [CNT_W-1:0]               rem_q, rem_d;
  logic                           word_valid_q, word_valid_d;
  logic [WORD_W-1:0]              word_data_q, word_data_d;
  logic [AW-1:0]                  word_addr_q, word_addr_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;

  logic [WORD_W-1:0]              w_raw, w_map, w_word;
  logic [AW-1:0]                  w_ptr_next;
  logic [CNT_W-1:0]               w_eff;
  logic                           w_hs;

  // Legacy mapping: lowest sector bit of a word lands in the output MSB.
  always_comb begin
    w_raw = buf_q[ptr_q];
    w_map = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w_map[WORD_W-1-i] = w_raw[i];
    end
`ifdef SD_RDIV_BYTESWAP_EN
    w_word = '0;
    for (int b = 0; b < NBYTES; b++) begin
      w_word[b*8 +: 8] = w_map[(NBYTES-1-b)*8 +: 8];
    end
`else
    w_word = w_map;
`endif
  end

  assign w_ptr_next = (ptr_q == AW'(NWORDS-1)) ? '0 : ptr_q + AW'(1);
  assign w_eff      = (bus.count > CNT_W'(NWORDS)) ? CNT_W'(NWORDS) : bus.count;
  assign w_hs       = word_valid_q & bus.word_ready;

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    word_addr_d  = word_addr_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (bus.sec_valid) begin
          buf_d   = bus.sec_data;
          state_d = ST_LOADED;
        end
        if (bus.start) begin
          err_d = 1'b1;
        end
      end
      ST_LOADED: begin
        if (bus.release_req) begin
          state_d = ST_EMPTY;
        end else if (bus.start) begin
          ptr_d = bus.start_addr;
          rem_d = w_eff;
          if (w_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        // Refill the output register on the first cycle and after every handshake.
        if (!word_valid_q || w_hs) begin
          if (rem_q != '0) begin
            word_valid_d = 1'b1;
            word_data_d  = w_word;
            word_addr_d  = ptr_q;
            ptr_d        = w_ptr_next;
            rem_d        = rem_q - CNT_W'(1);
          end else begin
            word_valid_d = 1'b0;
            state_d      = ST_LOADED;
            done_d       = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      ptr_q        <= '0;
      rem_q        <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_addr_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_addr_q  <= word_addr_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Buffer contents are meaningless while EMPTY, so no reset is needed.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.sec_ready  = (state_q == ST_EMPTY);
  assign bus.busy       = word_valid_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign bus.word_addr  = word_addr_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_sd_sector_word_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sd_sector_word_streamer                                        |
// | Brief  : Directed and randomized bench for sd_sector_word_streamer.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sd_sector_word_streamer;
  localparam int SB = 4096;
  localparam int WW = 32;
  localparam int NW = SB / WW;
  localparam int AW = $clog2(NW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_sector_word_streamer_if #(.SECTOR_BITS(SB), .WORD_W(WW)) bus ();

  sd_sector_word_streamer #(.SECTOR_BITS(SB), .WORD_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  logic [SB-1:0] sector;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference word for index k, built bit by bit from the sector image.
  function automatic logic [WW-1:0] exp_word(input int k);
    logic [WW-1:0] w;
    for (int i = 0; i < WW; i++) w[WW-1-i] = sector[k*WW+i];
`ifdef SD_RDIV_BYTESWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic load_sector();
    int cyc = 0;
    while (!bus.sec_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("ready_before_load", bus.sec_ready, 1);
    bus.sec_valid = 1'b1;
    bus.sec_data  = sector;
    @(posedge clk); #1;
    bus.sec_valid = 1'b0;
    chk("ready_after_load", bus.sec_ready, 0);
  endtask

  task automatic do_release();
    bus.release_req = 1'b1;
    @(posedge clk); #1;
    bus.release_req = 1'b0;
    chk("ready_after_release", bus.sec_ready, 1);
  endtask

  task automatic randomize_sector();
    for (int k = 0; k < NW; k++) sector[k*WW +: WW] = $urandom;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic run_burst(input int sa, input int cnt, input int mode);
    int eff, idx, cyc, pat, addr;
    logic rdy;
    eff = (cnt > NW) ? NW : cnt;
    bus.start      = 1'b1;
    bus.start_addr = AW'(sa);
    bus.count      = (AW+1)'(cnt);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_valid_low", bus.word_valid, 0);
    chk("start_busy_low", bus.busy, 0);
    if (eff == 0) begin
      chk("cnt0_done", bus.done, 1);
      @(posedge clk); #1;
      chk("cnt0_done_low", bus.done, 0);
      chk("cnt0_valid_low", bus.word_valid, 0);
      return;
    end
    chk("start_done_low", bus.done, 0);
    idx = 0; cyc = 0; pat = 0;
    while (idx < eff && cyc < 4*NW + 16) begin
      @(posedge clk); #1; cyc++;
      chk("stream_valid", bus.word_valid, 1);
      chk("stream_busy", bus.busy, 1);
      chk("stream_done_low", bus.done, 0);
      if (bus.word_valid) begin
        addr = (sa + idx) % NW;
        chk("word_addr", bus.word_addr, addr);
        chk("word_data", bus.word_data, exp_word(addr));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (pat % 4 == 0) || (pat % 4 == 3);
      endcase
      pat++;
      bus.word_ready = rdy;
      if (rdy && bus.word_valid) idx++;
    end
    if (idx < eff) chk("burst_timeout", idx, eff);
    @(posedge clk); #1;
    bus.word_ready = 1'b0;
    chk("end_done", bus.done, 1);
    chk("end_valid_low", bus.word_valid, 0);
    chk("end_busy_low", bus.busy, 0);
    @(posedge clk); #1;
    chk("end_done_low", bus.done, 0);
    chk("end_no_extra", bus.word_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    bus.sec_valid   = 1'b0;
    bus.sec_data    = '0;
    bus.release_req = 1'b0;
    bus.start       = 1'b0;
    bus.start_addr  = '0;
    bus.count       = '0;
    bus.word_ready  = 1'b0;

    #12;
    chk("rst_sec_ready", bus.sec_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.word_valid, 0);
    chk("rst_data", bus.word_data, 0);
    chk("rst_addr", bus.word_addr, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // One set bit at the base of every word
    sector = '0;
    for (int k = 0; k < NW; k++) sector[k*WW] = 1'b1;
    load_sector();
    run_burst(0, 4, 0);

    do_release();
    randomize_sector();
    load_sector();
    run_burst(126, 4, 0);
    run_burst(int'($urandom_range(0, NW-1)), 10, 2);
    run_burst(int'($urandom_range(0, NW-1)), 0, 0);
    run_burst(int'($urandom_range(0, NW-1)), 200, 1);
    for (int t = 0; t < 4; t++)
      run_burst(int'($urandom_range(0, NW-1)), int'($urandom_range(1, NW)), 1);

    // Capture attempts outside EMPTY must not disturb the buffer
    bus.sec_valid = 1'b1;
    bus.sec_data  = ~sector;
    run_burst(int'($urandom_range(0, NW-1)), 6, 1);
    bus.sec_valid = 1'b0;
    run_burst(int'($urandom_range(0, NW-1)), 6, 0);

    do_release();
    bus.start = 1'b1;
    bus.count = 8'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("empty_start_err", bus.err, 1);
    chk("empty_start_valid", bus.word_valid, 0);
    chk("empty_start_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("empty_err_low", bus.err, 0);
    chk("empty_sec_ready", bus.sec_ready, 1);

    randomize_sector();
    load_sector();
    bus.start       = 1'b1;
    bus.release_req = 1'b1;
    bus.count       = 8'd5;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.release_req = 1'b0;
    chk("conflict_sec_ready", bus.sec_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("conflict_no_word", bus.word_valid, 0);
      chk("conflict_no_done", bus.done, 0);
    end

    // Async reset while the third word of a burst is on the bus
    randomize_sector();
    load_sector();
    bus.word_ready = 1'b1;
    bus.start      = 1'b1;
    bus.start_addr = 7'd5;
    bus.count      = 8'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(posedge clk); #1;
      if (bus.word_valid && bus.word_addr == 7'd7) found = 1;
    end
    chk("third_word_seen", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_sec_ready", bus.sec_ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_valid", bus.word_valid, 0);
    chk("arst_data", bus.word_data, 0);
    chk("arst_addr", bus.word_addr, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_err", bus.err, 0);
    #1 rst = 1'b0;
    bus.word_ready = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_sec_ready", bus.sec_ready, 1);
    chk("post_rst_valid", bus.word_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
